seq_memory_ctrl: RTL and testbench
==================================

# seq_memory_ctrl

Parametrised pointer/flag controller for the Simon Says sequence memory. Turns a synchronised push-button into single-cycle write or read strobes with slot addresses, tracks how many steps are stored, and reports full/empty. It sits between the button front-end and the sequence RAM. The RAM is written during pattern entry and read back during playback.

## Interface
- `DEPTH`, default 30: number of sequence slots; legal range 2..255.
- `PTR_W`, default `$clog2(DEPTH+1)`: pointer/count width; derived and never overridden (5 for DEPTH=30).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `button` in 1: push-button level, already synchronised/debounced upstream.
- `mode` in 1: 1 = write (record), 0 = read (playback); sampled only on an accepted press.
- `clear` in 1: synchronous wipe of the stored sequence.
- `rewind` in 1: synchronous return of playback to slot 0.
- `w_en` out 1: one-cycle RAM write strobe.
- `w_addr` out PTR_W: slot written while `w_en`=1.
- `r_en` out 1: one-cycle RAM read strobe.
- `r_addr` out PTR_W: slot read while `r_en`=1.
- `w_ptr` out PTR_W: steps stored; next write slot; range 0..DEPTH.
- `r_ptr` out PTR_W: next playback slot; range 0..`w_ptr`.
- `fifo_full` out 1: `w_ptr`==DEPTH.
- `fifo_empty` out 1: no readable step (see Configuration).
- `replay_done` out 1: one-cycle pulse when playback wraps.

## Operation
- Press FSM has two states:
  - RELEASED → PRESSED when `button`=1; this edge is the accepted press.
  - PRESSED → RELEASED when `button`=0. A held button produces exactly one action.
- Write press (`mode`=1, not full): `w_en`<=1, `w_addr`<=`w_ptr`, `w_ptr`<=`w_ptr`+1.
- Write press when full: FSM still moves to PRESSED. No strobe, pointer unchanged; no wrap.
- Read press (`mode`=0, not empty): `r_en`<=1, `r_addr`<=`r_ptr`, `r_ptr`<=`r_ptr`+1, with wrap behaviour per Configuration.
- Read press when empty: ignored (FSM still moves to PRESSED).
- `clear`=1: `w_ptr`, `r_ptr`, `w_addr`, `r_addr` <= 0; strobes 0. `clear` beats any same-cycle press, which is consumed with no action.
- `rewind`=1: `r_ptr`<=0. It beats a same-cycle read press, which is consumed with no strobe. A same-cycle write press still executes.
- Flags are combinational from the registered pointers. Strobes are registered.
- Reset (asynchronous, while `reset`=0):
  - All pointers, addresses, `w_en`, `r_en`, `replay_done` = 0.
  - `fifo_full`=0, `fifo_empty`=1, FSM = RELEASED.
- Reset asserted mid-operation aborts immediately. A button still held after release counts as one new press.

## Timing
- Press seen at clock edge N: strobe and address valid during cycle N..N+1. Pointer and flags update at the same edge N.
- Strobes are high for exactly one cycle per press. The minimum press-to-press interval is 2 cycles (release + press).
- `replay_done` coincides with the `r_en` of the wrapping read.
- `clear` and `rewind` take effect at the edge where they are sampled high.

## Configuration
- `SEQ_REPLAY_EN` defined:
  - A read of slot `w_ptr`-1 sets `r_ptr`<=0 instead of `w_ptr`, and pulses `replay_done`.
  - `fifo_empty` = (`w_ptr`==0).
  - Playback loops indefinitely.
- `SEQ_REPLAY_EN` undefined:
  - `r_ptr` saturates at `w_ptr`; `fifo_empty` = (`r_ptr`==`w_ptr`).
  - `replay_done` is tied 0.
  - Playback restarts only via `rewind` or `clear`.

## Test plan
- Reset, then 3 write presses (`mode`=1) → `w_en` pulses with `w_addr`=0,1,2; `w_ptr`=3; `fifo_empty`=0 before any read when `SEQ_REPLAY_EN` is defined.
- Button held 10 cycles in write mode → exactly one `w_en`; `w_ptr` advances by 1.
- 30 write presses, then a 31st → `fifo_full`=1 after the 30th (`w_ptr`=30); the 31st gives no `w_en` and `w_ptr` stays 30.
- With 3 stored, 4 read presses:
  - Macro undefined → `r_addr`=0,1,2; `fifo_empty`=1; 4th ignored; `r_ptr`=3.
  - Macro defined → `r_addr`=0,1,2,0; `replay_done` on the 3rd read; `r_ptr`=1.
- `clear` together with a write press at `w_ptr`=5 → no `w_en`; `w_ptr`=`r_ptr`=0; `fifo_empty`=1.
- `reset` driven low mid-playback (`r_ptr`=2) with button held through release → all outputs reset immediately; first edge after release gives one read press. Since `fifo_empty`=1, there is no `r_en`.

Source files
------------

// File: rtl/seq_memory_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_memory_ctrl_if
// Description : Button-side controls and RAM-side strobes/pointers/flags of
//               the Simon Says sequence memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_memory_ctrl_if #(
    parameter int PTR_W = 5
);
    logic             button;
    logic             mode;
    logic             clear;
    logic             rewind;
    logic             w_en;
    logic [PTR_W-1:0] w_addr;
    logic             r_en;
    logic [PTR_W-1:0] r_addr;
    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] r_ptr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             replay_done;

    modport master (
        output button, mode, clear, rewind,
        input  w_en, w_addr, r_en, r_addr, w_ptr, r_ptr,
        input  fifo_full, fifo_empty, replay_done
    );

    modport slave (
        input  button, mode, clear, rewind,
        output w_en, w_addr, r_en, r_addr, w_ptr, r_ptr,
        output fifo_full, fifo_empty, replay_done
    );
endinterface
`default_nettype wire

// File: rtl/seq_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_memory_ctrl
// Description : Pointer/flag controller for the sequence RAM. Converts each
//               button press into one registered write or read strobe.
//               Define SEQ_REPLAY_EN for looping playback with replay_done.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_memory_ctrl #(
    parameter int DEPTH = 30,
    parameter int PTR_W = $clog2(DEPTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    seq_memory_ctrl_if.slave   bus
);

    localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_ONE   = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
    logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
    logic [PTR_W-1:0] w_addr_q, w_addr_d;
    logic [PTR_W-1:0] r_addr_q, r_addr_d;
    logic             w_en_q, w_en_d;
    logic             r_en_q, r_en_d;
`ifdef SEQ_REPLAY_EN
    logic             replay_done_q, replay_done_d;
`endif

    logic w_press;
    logic w_full;
    logic w_empty;

    assign w_press = (state_q == ST_RELEASED) && bus.button;
    assign w_full  = (w_ptr_q == C_DEPTH);
`ifdef SEQ_REPLAY_EN
    assign w_empty = (w_ptr_q == '0);
`else
    assign w_empty = (r_ptr_q == w_ptr_q);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RELEASED;
            w_ptr_q  <= '0;
            r_ptr_q  <= '0;
            w_addr_q <= '0;
            r_addr_q <= '0;
            w_en_q   <= 1'b0;
            r_en_q   <= 1'b0;
`ifdef SEQ_REPLAY_EN
            replay_done_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            w_ptr_q  <= w_ptr_d;
            r_ptr_q  <= r_ptr_d;
            w_addr_q <= w_addr_d;
            r_addr_q <= r_addr_d;
            w_en_q   <= w_en_d;
            r_en_q   <= r_en_d;
`ifdef SEQ_REPLAY_EN
            replay_done_q <= replay_done_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        w_ptr_d  = w_ptr_q;
        r_ptr_d  = r_ptr_q;
        w_addr_d = w_addr_q;
        r_addr_d = r_addr_q;
        w_en_d   = 1'b0;
        r_en_d   = 1'b0;
`ifdef SEQ_REPLAY_EN
        replay_done_d = 1'b0;
`endif

        case (state_q)
            ST_RELEASED: if (bus.button)  state_d = ST_PRESSED;
            ST_PRESSED:  if (!bus.button) state_d = ST_RELEASED;
            default:                      state_d = ST_RELEASED;
        endcase

        // The FSM advances regardless; clear/rewind only suppress the action.
        if (bus.clear) begin
            w_ptr_d  = '0;
            r_ptr_d  = '0;
            w_addr_d = '0;
            r_addr_d = '0;
        end else begin
            if (bus.rewind) begin
                r_ptr_d = '0;
            end
            if (w_press && bus.mode && !w_full) begin
                w_en_d   = 1'b1;
                w_addr_d = w_ptr_q;
                w_ptr_d  = w_ptr_q + C_ONE;
            end else if (w_press && !bus.mode && !bus.rewind && !w_empty) begin
                r_en_d   = 1'b1;
                r_addr_d = r_ptr_q;
`ifdef SEQ_REPLAY_EN
                if (r_ptr_q == w_ptr_q - C_ONE) begin
                    r_ptr_d       = '0;
                    replay_done_d = 1'b1;
                end else begin
                    r_ptr_d = r_ptr_q + C_ONE;
                end
`else
                r_ptr_d = r_ptr_q + C_ONE;
`endif
            end
        end
    end

    assign bus.w_en       = w_en_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.r_en       = r_en_q;
    assign bus.r_addr     = r_addr_q;
    assign bus.w_ptr      = w_ptr_q;
    assign bus.r_ptr      = r_ptr_q;
    assign bus.fifo_full  = w_full;
    assign bus.fifo_empty = w_empty;
`ifdef SEQ_REPLAY_EN
    assign bus.replay_done = replay_done_q;
`else
    assign bus.replay_done = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_memory_ctrl
// Description : Self-checking bench: vector table, corner-case sequences and
//               randomized stimulus against a step-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_memory_ctrl;

    localparam int DEPTH = 30;
    localparam int PTR_W = 5;

    logic clk;
    logic reset;

    seq_memory_ctrl_if #(.PTR_W(PTR_W)) bus ();

    seq_memory_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: number of stored steps and playback position.
    int m_stored, m_play, m_waddr, m_raddr;
    bit m_wen, m_ren, m_done, m_held;

    typedef struct {
        logic b, m, c, rw;
        logic e_wen;
        int   e_waddr;
        logic e_ren;
        int   e_raddr;
        int   e_wptr;
        int   e_rptr;
        logic e_full, e_empty, e_done;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic b, logic m, logic c, logic rw,
                                logic wen, int waddr, logic ren, int raddr,
                                int wptr, int rptr, logic empty);
        vec_t v;
        v.b = b; v.m = m; v.c = c; v.rw = rw;
        v.e_wen = wen; v.e_waddr = waddr; v.e_ren = ren; v.e_raddr = raddr;
        v.e_wptr = wptr; v.e_rptr = rptr;
        v.e_full = 1'b0; v.e_empty = empty; v.e_done = 1'b0;
        return v;
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_readable();
`ifdef SEQ_REPLAY_EN
        return m_stored > 0;
`else
        return m_play < m_stored;
`endif
    endfunction

    task automatic model_reset();
        m_stored = 0; m_play = 0; m_waddr = 0; m_raddr = 0;
        m_wen = 0; m_ren = 0; m_done = 0; m_held = 0;
    endtask

    task automatic model_step(input bit b, input bit md, input bit c, input bit rw);
        bit press;
        bit can_read;
        press    = b && !m_held;
        m_held   = b;
        can_read = m_readable();
        m_wen = 0; m_ren = 0; m_done = 0;
        if (c) begin
            m_stored = 0; m_play = 0; m_waddr = 0; m_raddr = 0;
        end else begin
            if (rw) m_play = 0;
            if (press && md && m_stored < DEPTH) begin
                m_wen = 1; m_waddr = m_stored; m_stored++;
            end else if (press && !md && !rw && can_read) begin
                m_ren = 1; m_raddr = m_play; m_play++;
`ifdef SEQ_REPLAY_EN
                if (m_play == m_stored) begin
                    m_play = 0; m_done = 1;
                end
`endif
            end
        end
    endtask

    task automatic check_model();
        check_val("w_en",        int'(bus.w_en),        int'(m_wen));
        check_val("w_addr",      int'(bus.w_addr),      m_waddr);
        check_val("r_en",        int'(bus.r_en),        int'(m_ren));
        check_val("r_addr",      int'(bus.r_addr),      m_raddr);
        check_val("w_ptr",       int'(bus.w_ptr),       m_stored);
        check_val("r_ptr",       int'(bus.r_ptr),       m_play);
        check_val("fifo_full",   int'(bus.fifo_full),   int'(m_stored == DEPTH));
        check_val("fifo_empty",  int'(bus.fifo_empty),  int'(!m_readable()));
        check_val("replay_done", int'(bus.replay_done), int'(m_done));
    endtask

    // Drive inputs for one cycle, advance the model at the edge, compare after it.
    task automatic step(input bit b, input bit md, input bit c, input bit rw);
        bus.button = b; bus.mode = md; bus.clear = c; bus.rewind = rw;
        @(posedge clk);
        model_step(b, md, c, rw);
        #1;
        check_model();
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " w_en"},        int'(bus.w_en),        0);
        check_val({tag, " r_en"},        int'(bus.r_en),        0);
        check_val({tag, " w_ptr"},       int'(bus.w_ptr),       0);
        check_val({tag, " r_ptr"},       int'(bus.r_ptr),       0);
        check_val({tag, " w_addr"},      int'(bus.w_addr),      0);
        check_val({tag, " r_addr"},      int'(bus.r_addr),      0);
        check_val({tag, " fifo_full"},   int'(bus.fifo_full),   0);
        check_val({tag, " fifo_empty"},  int'(bus.fifo_empty),  1);
        check_val({tag, " replay_done"}, int'(bus.replay_done), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int raddrs[4];
        bit dones[4];

        checks = 0; failures = 0;
        bus.button = 0; bus.mode = 0; bus.clear = 0; bus.rewind = 0;
        reset = 1'b1;
        model_reset();
        #2;

        // Vector table (expectations identical in both builds: no wrap occurs)
        vecs[0]  = mk(1,1,0,0, 1,0, 0,0, 1,0, 0);
        vecs[1]  = mk(0,1,0,0, 0,0, 0,0, 1,0, 0);
        vecs[2]  = mk(1,1,0,0, 1,1, 0,0, 2,0, 0);
        vecs[3]  = mk(0,1,0,0, 0,1, 0,0, 2,0, 0);
        vecs[4]  = mk(1,1,0,0, 1,2, 0,0, 3,0, 0);
        vecs[5]  = mk(1,1,0,0, 0,2, 0,0, 3,0, 0);
        vecs[6]  = mk(0,0,0,0, 0,2, 0,0, 3,0, 0);
        vecs[7]  = mk(1,0,0,0, 0,2, 1,0, 3,1, 0);
        vecs[8]  = mk(0,0,0,0, 0,2, 0,0, 3,1, 0);
        vecs[9]  = mk(1,0,0,0, 0,2, 1,1, 3,2, 0);
        vecs[10] = mk(0,0,0,0, 0,2, 0,1, 3,2, 0);
        vecs[11] = mk(1,0,0,1, 0,2, 0,1, 3,0, 0);
        vecs[12] = mk(0,0,0,0, 0,2, 0,1, 3,0, 0);
        vecs[13] = mk(1,1,1,0, 0,0, 0,0, 0,0, 1);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].b, vecs[i].m, vecs[i].c, vecs[i].rw);
            check_val($sformatf("vec%0d w_en", i),   int'(bus.w_en),       int'(vecs[i].e_wen));
            check_val($sformatf("vec%0d w_addr", i), int'(bus.w_addr),     vecs[i].e_waddr);
            check_val($sformatf("vec%0d r_en", i),   int'(bus.r_en),       int'(vecs[i].e_ren));
            check_val($sformatf("vec%0d r_addr", i), int'(bus.r_addr),     vecs[i].e_raddr);
            check_val($sformatf("vec%0d w_ptr", i),  int'(bus.w_ptr),      vecs[i].e_wptr);
            check_val($sformatf("vec%0d r_ptr", i),  int'(bus.r_ptr),      vecs[i].e_rptr);
            check_val($sformatf("vec%0d full", i),   int'(bus.fifo_full),  int'(vecs[i].e_full));
            check_val($sformatf("vec%0d empty", i),  int'(bus.fifo_empty), int'(vecs[i].e_empty));
            check_val($sformatf("vec%0d done", i),   int'(bus.replay_done), int'(vecs[i].e_done));
        end
        step(0,0,0,0);

        // Fill to DEPTH, then one press too many
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1,1,0,0);
            step(0,1,0,0);
        end
        check_val("full after 30", int'(bus.fifo_full), 1);
        check_val("w_ptr after 30", int'(bus.w_ptr), DEPTH);
        step(1,1,0,0);
        check_val("31st w_en", int'(bus.w_en), 0);
        check_val("31st w_ptr", int'(bus.w_ptr), DEPTH);
        step(0,1,0,0);

        // Clear together with a write press at w_ptr=5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1,1,0,0);
            step(0,1,0,0);
        end
        step(1,1,1,0);
        check_val("clear+press w_en", int'(bus.w_en), 0);
        check_val("clear w_ptr", int'(bus.w_ptr), 0);
        check_val("clear empty", int'(bus.fifo_empty), 1);
        step(0,1,0,0);

        // Three stored, four reads
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1,1,0,0);
            step(0,1,0,0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1,0,0,0);
            raddrs[i] = int'(bus.r_addr);
            dones[i]  = bus.replay_done;
            if (i == 3) begin
`ifdef SEQ_REPLAY_EN
                check_val("4th read r_en", int'(bus.r_en), 1);
`else
                check_val("4th read r_en", int'(bus.r_en), 0);
`endif
            end
            step(0,0,0,0);
        end
        check_val("read0 addr", raddrs[0], 0);
        check_val("read1 addr", raddrs[1], 1);
        check_val("read2 addr", raddrs[2], 2);
`ifdef SEQ_REPLAY_EN
        check_val("read3 addr", raddrs[3], 0);
        check_val("read2 done", int'(dones[2]), 1);
        check_val("final r_ptr", int'(bus.r_ptr), 1);
        check_val("final empty", int'(bus.fifo_empty), 0);
`else
        check_val("read3 addr", raddrs[3], 2);
        check_val("read2 done", int'(dones[2]), 0);
        check_val("final r_ptr", int'(bus.r_ptr), 3);
        check_val("final empty", int'(bus.fifo_empty), 1);
`endif

        // Reset mid-playback with the button held through release
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1,1,0,0);
            step(0,1,0,0);
        end
        for (int i = 0; i < 2; i++) begin
            step(1,0,0,0);
            step(0,0,0,0);
        end
        check_val("pre-reset r_ptr", int'(bus.r_ptr), 2);
        bus.button = 1; bus.mode = 0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("async");
        @(posedge clk);
        #1;
        check_reset_state("held");
        reset = 1'b1;
        model_reset();
        step(1,0,0,0);
        check_val("post-reset r_en", int'(bus.r_en), 0);
        step(1,0,0,0);
        step(0,0,0,0);

        // Randomized stimulus against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 149) == 0,
                 $urandom_range(0, 29) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
